// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: command sequencer for a 4-bit control register.
//   Accepts one command at a time on a cmd_valid/cmd_ready handshake.
//   It then drives the register controls for the programmed number of steps and
//   pulses done (qualified by aborted) once reg_q holds the final value.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op[2:0]                     0 CLR,1 LD,2 INC,3 DEC,4 SHR,5 SHL,6 ROR,7 ROL
//   cmd_cnt[3:0], cmd_data[3:0]     step count (ops 2-7), load value (LD)
//   abort                           cut the running command short
//   reg_q[3:0]                      register feedback (rotate serial-in source)
//   reg_cl/ld/inc/dec/sr/sl         register control lines
//   reg_ir/reg_il, reg_d[3:0]       serial-in bits, parallel load data
//   busy, done, aborted             status
// Control outputs are a decode of the registered state, live abort and reg_q.
// They must act on the register in the same cycle they are decoded.
module reg_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_cnt,
  input  logic [3:0] cmd_data,
  input  logic       abort,
  input  logic [3:0] reg_q,
  output logic       reg_cl,
  output logic       reg_ld,
  output logic       reg_inc,
  output logic       reg_dec,
  output logic       reg_sr,
  output logic       reg_sl,
  output logic       reg_ir,
  output logic       reg_il,
  output logic [3:0] reg_d,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam int unsigned DW  = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_CLR = 3'd0;
  localparam logic [OPW-1:0] OP_LD  = 3'd1;
  localparam logic [OPW-1:0] OP_INC = 3'd2;
  localparam logic [OPW-1:0] OP_DEC = 3'd3;
  localparam logic [OPW-1:0] OP_SHR = 3'd4;
  localparam logic [OPW-1:0] OP_SHL = 3'd5;
  localparam logic [OPW-1:0] OP_ROR = 3'd6;
  localparam logic [OPW-1:0] OP_ROL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic [DW-1:0]  data_q, data_d;
  logic           abt_q, abt_d;
  logic           step_en;

  // Only the end bits of reg_q feed the rotate serial inputs.
  logic unused_mid_bits;
  assign unused_mid_bits = ^reg_q[2:1];

  // State and latched command fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      abt_q   <= abt_d;
    end
  end

  // Next-state and command latching.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    data_d  = data_q;
    abt_d   = abt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          abt_d  = 1'b0;
          if (cmd_op == OP_CLR || cmd_op == OP_LD) begin
            rem_d   = CW'(1);
            state_d = ST_EXEC;
          end else if (cmd_cnt == '0) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            rem_d   = cmd_cnt;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (abort) begin
          abt_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control decode; an abort suppresses the step of the cycle it appears in.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    aborted   = (state_q == ST_DONE) && abt_q;
    step_en   = (state_q == ST_EXEC) && !abort;
    reg_cl    = 1'b0;
    reg_ld    = 1'b0;
    reg_inc   = 1'b0;
    reg_dec   = 1'b0;
    reg_sr    = 1'b0;
    reg_sl    = 1'b0;
    reg_ir    = 1'b0;
    reg_il    = 1'b0;
    reg_d     = '0;
    if (step_en) begin
      unique case (op_q)
        OP_CLR: reg_cl = 1'b1;
        OP_LD: begin
          reg_ld = 1'b1;
          reg_d  = data_q;
        end
        OP_INC: reg_inc = 1'b1;
        OP_DEC: reg_dec = 1'b1;
        OP_SHR: reg_sr  = 1'b1;
        OP_SHL: reg_sl  = 1'b1;
        OP_ROR: begin
          reg_sr = 1'b1;
          reg_ir = reg_q[0];
        end
        OP_ROL: begin
          reg_sl = 1'b1;
          reg_il = reg_q[DW-1];
        end
        default: ;
      endcase
    end
  end

endmodule
